// File: rtl/food_spawner_if.sv
// -----------------------------------------------------------------------------
// food_spawner_if
// Occupancy query port between the food spawner and the snake body store.
// A query is a one-cycle strobe (occ_req) carrying the cell coordinates; the
// store answers on `occupied` exactly one cycle later.
//
//   occ_req   spawner -> store   query strobe
//   occ_x     spawner -> store   queried column
//   occ_y     spawner -> store   queried row
//   occupied  store -> spawner   answer, valid the cycle after occ_req
//
// Modports: master = spawner side, slave = occupancy store side.
// -----------------------------------------------------------------------------
interface food_spawner_if #(
    parameter int COORD_W = 4
) ();
    logic               occ_req;
    logic [COORD_W-1:0] occ_x;
    logic [COORD_W-1:0] occ_y;
    logic               occupied;

    modport master (
        output occ_req,
        output occ_x,
        output occ_y,
        input  occupied
    );

    modport slave (
        input  occ_req,
        input  occ_x,
        input  occ_y,
        output occupied
    );
endinterface

// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
// Places food on the snake grid and produces the `win` pulse counted by the
// score counter. Candidate cells come from a free-running 16-bit Galois LFSR
// and are checked against the body store through the occupancy port. After
// MAX_TRIES occupied random candidates the block falls back to a row-major scan
// of the whole grid; if every cell is occupied it raises a sticky board_full.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            game running; low freezes FSM/tries/scan pointer, win=0
//   move_tick         one-cycle strobe, head_x/head_y valid with it
//   head_x, head_y    snake head coordinates
//   occ               occupancy query port (food_spawner_if.master)
//   food_x, food_y    current food cell
//   food_valid        food placed and displayable
//   win               food eaten pulse
//   board_full        no free cell exists; sticky until reset
//   food_bonus        current food is bonus food
//
// Optional feature, macro FOOD_BONUS_EN:
//   every 5th placement since reset is bonus food; eating it holds win high
//   for two consecutive cycles. Without the macro food_bonus is tied 0.
// -----------------------------------------------------------------------------
module food_spawner #(
    parameter int          GRID_W    = 16,
    parameter int          GRID_H    = 16,
    parameter int          COORD_W   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               move_tick,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    food_spawner_if.master     occ,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               win,
    output logic               board_full,
    output logic               food_bonus
);

    localparam int                 TRIES_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(MAX_TRIES);
    localparam logic [COORD_W:0]   GRID_W_L    = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0]   GRID_H_L    = (COORD_W + 1)'(GRID_H);
    localparam logic [COORD_W-1:0] LAST_X      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y      = COORD_W'(GRID_H - 1);
    // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0]        LFSR_TAPS   = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        QUERY,
        CHECK,
        SCAN_Q,
        SCAN_C,
        PLACED,
        FULL
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [COORD_W-1:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic               food_valid_q, food_valid_d;
    logic               win_q, win_d;
    logic               board_full_q, board_full_d;
    // pend_q marks that a query went out last cycle; resp_q keeps its answer
    // so a CHECK stalled by enable=0 still sees the right response later.
    logic               pend_q, pend_d;
    logic               resp_q, resp_d;

`ifdef FOOD_BONUS_EN
    logic [2:0]         bonus_cnt_q, bonus_cnt_d;
    logic               food_bonus_q, food_bonus_d;
    logic               win2_q, win2_d;
`endif

    logic [COORD_W-1:0] lfsr_x, lfsr_y;
    logic               out_of_range;
    logic               occ_req_w;
    logic               occ_now;
    logic [TRIES_W-1:0] tries_inc;
    logic               place;
    logic [COORD_W-1:0] place_x, place_y;

    assign lfsr_x       = lfsr_q[COORD_W-1:0];
    assign lfsr_y       = lfsr_q[2*COORD_W-1:COORD_W];
    assign out_of_range = ({1'b0, lfsr_x} >= GRID_W_L) || ({1'b0, lfsr_y} >= GRID_H_L);
    assign tries_inc    = tries_q + TRIES_W'(1);
    assign occ_now      = pend_q ? occ.occupied : resp_q;

    // A query is only issued on an enabled QUERY/SCAN_Q cycle, so a frozen FSM
    // never repeats the strobe and at most one query is ever outstanding.
    assign occ_req_w    = enable && ((state_q == QUERY) || (state_q == SCAN_Q));

    always_comb begin
        occ.occ_req = occ_req_w;
        occ.occ_x   = '0;
        occ.occ_y   = '0;
        if (state_q == QUERY) begin
            occ.occ_x = cand_x_q;
            occ.occ_y = cand_y_q;
        end else if (state_q == SCAN_Q) begin
            occ.occ_x = scan_x_q;
            occ.occ_y = scan_y_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        tries_d      = tries_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        win_d        = 1'b0;
        board_full_d = board_full_q;
        pend_d       = occ_req_w;
        resp_d       = pend_q ? occ.occupied : resp_q;
        place        = 1'b0;
        place_x      = '0;
        place_y      = '0;
`ifdef FOOD_BONUS_EN
        bonus_cnt_d  = bonus_cnt_q;
        food_bonus_d = food_bonus_q;
        win2_d       = win2_q;
`endif

        if (enable) begin
            case (state_q)
                IDLE: state_d = SPAWN;

                SPAWN: begin
                    cand_x_d = lfsr_x;
                    cand_y_d = lfsr_y;
                    if (out_of_range) begin
                        // An off-grid sample is a failed try without a query.
                        if (tries_inc == TRIES_LIMIT) begin
                            tries_d  = '0;
                            scan_x_d = '0;
                            scan_y_d = '0;
                            state_d  = SCAN_Q;
                        end else begin
                            tries_d  = tries_inc;
                        end
                    end else begin
                        state_d = QUERY;
                    end
                end

                QUERY: state_d = CHECK;

                CHECK: begin
                    if (!occ_now) begin
                        place   = 1'b1;
                        place_x = cand_x_q;
                        place_y = cand_y_q;
                    end else if (tries_inc == TRIES_LIMIT) begin
                        tries_d  = '0;
                        scan_x_d = '0;
                        scan_y_d = '0;
                        state_d  = SCAN_Q;
                    end else begin
                        tries_d = tries_inc;
                        state_d = SPAWN;
                    end
                end

                SCAN_Q: state_d = SCAN_C;

                SCAN_C: begin
                    if (!occ_now) begin
                        place   = 1'b1;
                        place_x = scan_x_q;
                        place_y = scan_y_q;
                    end else if ((scan_x_q == LAST_X) && (scan_y_q == LAST_Y)) begin
                        board_full_d = 1'b1;
                        state_d      = FULL;
                    end else begin
                        if (scan_x_q == LAST_X) begin
                            scan_x_d = '0;
                            scan_y_d = scan_y_q + COORD_W'(1);
                        end else begin
                            scan_x_d = scan_x_q + COORD_W'(1);
                        end
                        state_d = SCAN_Q;
                    end
                end

                PLACED: begin
                    if (move_tick && (head_x == food_x_q) && (head_y == food_y_q)) begin
                        win_d        = 1'b1;
                        food_valid_d = 1'b0;
                        state_d      = SPAWN;
`ifdef FOOD_BONUS_EN
                        win2_d       = food_bonus_q;
                        food_bonus_d = 1'b0;
`endif
                    end
                end

                FULL: state_d = FULL;

                default: state_d = IDLE;
            endcase

`ifdef FOOD_BONUS_EN
            // Second win cycle for bonus food, issued the cycle after the first.
            if (win2_q) begin
                win_d  = 1'b1;
                win2_d = 1'b0;
            end
`endif

            if (place) begin
                food_x_d     = place_x;
                food_y_d     = place_y;
                food_valid_d = 1'b1;
                tries_d      = '0;
                state_d      = PLACED;
`ifdef FOOD_BONUS_EN
                if (bonus_cnt_q == 3'd4) begin
                    bonus_cnt_d  = 3'd0;
                    food_bonus_d = 1'b1;
                end else begin
                    bonus_cnt_d  = bonus_cnt_q + 3'd1;
                    food_bonus_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            tries_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            win_q        <= 1'b0;
            board_full_q <= 1'b0;
            pend_q       <= 1'b0;
            resp_q       <= 1'b0;
`ifdef FOOD_BONUS_EN
            bonus_cnt_q  <= 3'd0;
            food_bonus_q <= 1'b0;
            win2_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tries_q      <= tries_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            win_q        <= win_d;
            board_full_q <= board_full_d;
            pend_q       <= pend_d;
            resp_q       <= resp_d;
`ifdef FOOD_BONUS_EN
            bonus_cnt_q  <= bonus_cnt_d;
            food_bonus_q <= food_bonus_d;
            win2_q       <= win2_d;
`endif
        end
    end

    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign board_full = board_full_q;
    // enable=0 suppresses win immediately, not just from the next edge.
    assign win        = win_q & enable;
`ifdef FOOD_BONUS_EN
    assign food_bonus = food_bonus_q;
`else
    assign food_bonus = 1'b0;
`endif

endmodule

// File: tb/tb_food_spawner.sv
// -----------------------------------------------------------------------------
// tb_food_spawner
// Directed bench for food_spawner on a 4x4 grid with 2-bit coordinates, so
// every LFSR sample is on-grid and the random/scan query sequence is fixed.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_food_spawner;

    localparam int CW = 2;
    localparam int GW = 4;
    localparam int GH = 4;
    localparam int MT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          move_tick = 1'b0;
    logic [CW-1:0] head_x = '0;
    logic [CW-1:0] head_y = '0;
    logic [CW-1:0] food_x, food_y;
    logic          food_valid, win, board_full, food_bonus;

    always #5 clk = ~clk;

    food_spawner_if #(.COORD_W(CW)) occ_if ();

    food_spawner #(
        .GRID_W    (GW),
        .GRID_H    (GH),
        .COORD_W   (CW),
        .LFSR_SEED (16'hACE1),
        .MAX_TRIES (MT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .move_tick  (move_tick),
        .head_x     (head_x),
        .head_y     (head_y),
        .occ        (occ_if.master),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .win        (win),
        .board_full (board_full),
        .food_bonus (food_bonus)
    );

    int checks = 0;
    int errors = 0;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, shifting right.
    logic [15:0] m_lfsr, m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
        m_prev <= m_lfsr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    logic prev_req = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (occ_if.occ_req) chk("occ_req_back_to_back", prev_req, 1'b0);
        prev_req = occ_if.occ_req;
    endtask

    logic [CW-1:0] fx, fy, ex, ey, hx, hy;

    // Run until food appears (occupied held 0); checks query and placed cell.
    task automatic wait_place(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (occ_if.occ_req) begin
                ex = m_prev[CW-1:0];
                ey = m_prev[2*CW-1:CW];
                chk({tag, "_qx"}, occ_if.occ_x, ex);
                chk({tag, "_qy"}, occ_if.occ_y, ey);
            end
            if (food_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout({tag, "_place"});
        else begin
            chk({tag, "_food_x"}, food_x, ex);
            chk({tag, "_food_y"}, food_y, ey);
`ifndef FOOD_BONUS_EN
            chk({tag, "_bonus"}, food_bonus, 1'b0);
`endif
            fx = ex;
            fy = ey;
        end
    endtask

    task automatic eat(input string tag);
        head_x = fx;
        head_y = fy;
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        chk({tag, "_win"}, win, 1'b1);
        chk({tag, "_valid_clr"}, food_valid, 1'b0);
    endtask

    initial begin
        int nreq;
        int k;
        bit ok;
        occ_if.occupied = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_occ_req", occ_if.occ_req, 1'b0);
        chk("rst_occ_x", occ_if.occ_x, 2'd0);
        chk("rst_food_valid", food_valid, 1'b0);
        chk("rst_food_x", food_x, 2'd0);
        chk("rst_food_y", food_y, 2'd0);
        chk("rst_win", win, 1'b0);
        chk("rst_board_full", board_full, 1'b0);
        chk("rst_food_bonus", food_bonus, 1'b0);
        enable = 1'b1;
        tick();
        chk("rst_priority_req", occ_if.occ_req, 1'b0);

        // ---------------- first spawn latency ----------------
        reset = 1'b0;                   // cycle 1: IDLE
        tick();                         // cycle 2: SPAWN
        chk("c2_occ_req", occ_if.occ_req, 1'b0);
        tick();                         // cycle 3: QUERY
        chk("c3_occ_req", occ_if.occ_req, 1'b1);
        ex = m_prev[CW-1:0];
        ey = m_prev[2*CW-1:CW];
        chk("c3_occ_x", occ_if.occ_x, ex);
        chk("c3_occ_y", occ_if.occ_y, ey);
        tick();                         // cycle 4: CHECK
        chk("c4_occ_req", occ_if.occ_req, 1'b0);
        chk("c4_food_valid", food_valid, 1'b0);
        tick();                         // cycle 5: PLACED
        chk("c5_food_valid", food_valid, 1'b1);
        chk("c5_food_x", food_x, ex);
        chk("c5_food_y", food_y, ey);
        fx = ex;
        fy = ey;
        $display("placed first food at (%0d,%0d)", fx, fy);

        // ---------------- eating ----------------
        head_x = fx + 2'd1;
        head_y = fy;
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        chk("miss_win", win, 1'b0);
        chk("miss_valid", food_valid, 1'b1);
        eat("eat1");
        chk("eat1_no_req", occ_if.occ_req, 1'b0);
        tick();
        chk("eat1_win_once", win, 1'b0);
        chk("eat1_req_2later", occ_if.occ_req, 1'b1);
        ex = m_prev[CW-1:0];
        ey = m_prev[2*CW-1:CW];
        chk("eat1_qx", occ_if.occ_x, ex);
        chk("eat1_qy", occ_if.occ_y, ey);
        // a head on the future food cell before placement must not score
        head_x = ex;
        head_y = ey;
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        chk("nofood_win", win, 1'b0);
        tick();
        chk("eat1_T3_valid", food_valid, 1'b1);
        chk("eat1_T3_win", win, 1'b0);
        chk("eat1_food_x", food_x, ex);
        chk("eat1_food_y", food_y, ey);
        fx = ex;
        fy = ey;
        $display("respawned food at (%0d,%0d)", fx, fy);

        // ---------------- three collisions then free ----------------
        eat("eat2");
        occ_if.occupied = 1'b1;
        nreq = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (occ_if.occ_req) begin
                nreq++;
                ex = m_prev[CW-1:0];
                ey = m_prev[2*CW-1:CW];
                chk("coll_qx", occ_if.occ_x, ex);
                chk("coll_qy", occ_if.occ_y, ey);
                if (nreq == 4) occ_if.occupied = 1'b0;
            end
            if (food_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("coll_place");
        chk("coll_nreq", nreq, 4);
        chk("coll_food_x", food_x, ex);
        chk("coll_food_y", food_y, ey);
        fx = ex;
        fy = ey;
        $display("placed after 3 collisions at (%0d,%0d)", fx, fy);

        // ---------------- full board: random then scan ----------------
        eat("eat3");
        occ_if.occupied = 1'b1;
        nreq = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (occ_if.occ_req) begin
                nreq++;
                if (nreq <= MT) begin
                    chk("rand_qx", occ_if.occ_x, m_prev[CW-1:0]);
                    chk("rand_qy", occ_if.occ_y, m_prev[2*CW-1:CW]);
                end else begin
                    k = nreq - MT - 1;
                    chk("scan_qx", occ_if.occ_x, k % GW);
                    chk("scan_qy", occ_if.occ_y, k / GW);
                end
            end
            if (board_full) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("full_board");
        chk("full_nreq", nreq, MT + GW * GH);
        chk("full_flag", board_full, 1'b1);
        chk("full_valid", food_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_no_req", occ_if.occ_req, 1'b0);
        end
        chk("full_sticky", board_full, 1'b1);
        chk("full_win", win, 1'b0);
        $display("board full after %0d queries", nreq);

        // ---------------- reset out of FULL ----------------
        reset = 1'b1;
        tick();
        chk("rst2_board_full", board_full, 1'b0);
        chk("rst2_valid", food_valid, 1'b0);
        chk("rst2_food_x", food_x, 2'd0);
        reset = 1'b0;
        occ_if.occupied = 1'b0;
        wait_place("rst2");

        // ---------------- enable low in PLACED ----------------
        enable = 1'b0;
        head_x = fx;
        head_y = fy;
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        chk("dis_placed_win", win, 1'b0);
        chk("dis_placed_valid", food_valid, 1'b1);
        enable = 1'b1;
        tick();
        chk("dis_placed_keep", food_valid, 1'b1);
        chk("dis_placed_win2", win, 1'b0);

        // ---------------- enable low in QUERY ----------------
        eat("eat4");
        tick();
        chk("dis_q_req", occ_if.occ_req, 1'b1);
        hx = m_prev[CW-1:0];
        hy = m_prev[2*CW-1:CW];
        chk("dis_q_x", occ_if.occ_x, hx);
        enable = 1'b0;
        #1;
        chk("dis_q_req_off", occ_if.occ_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            head_x = fx;
            head_y = fy;
            move_tick = 1'b1;
            tick();
            chk("dis_q_hold_x", occ_if.occ_x, hx);
            chk("dis_q_hold_y", occ_if.occ_y, hy);
            chk("dis_q_no_req", occ_if.occ_req, 1'b0);
            chk("dis_q_win", win, 1'b0);
        end
        move_tick = 1'b0;
        enable = 1'b1;
        #1;
        chk("dis_q_resume_req", occ_if.occ_req, 1'b1);
        tick();
        chk("dis_q_check", occ_if.occ_req, 1'b0);
        tick();
        chk("dis_q_valid", food_valid, 1'b1);
        chk("dis_q_food_x", food_x, hx);
        chk("dis_q_food_y", food_y, hy);
        fx = hx;
        fy = hy;
        $display("resumed after freeze, food at (%0d,%0d)", fx, fy);

        // ---------------- reset mid-scan ----------------
        eat("eat5");
        occ_if.occupied = 1'b1;
        nreq = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (occ_if.occ_req) nreq++;
            if (nreq == MT + 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("midscan_reach");
        reset = 1'b1;
        tick();
        chk("midscan_rst_req", occ_if.occ_req, 1'b0);
        chk("midscan_rst_x", occ_if.occ_x, 2'd0);
        chk("midscan_rst_valid", food_valid, 1'b0);
        chk("midscan_rst_full", board_full, 1'b0);
        chk("midscan_rst_win", win, 1'b0);
        reset = 1'b0;
        tick();
        occ_if.occupied = 1'b0;
        wait_place("midscan_restart");

`ifdef FOOD_BONUS_EN
        // ---------------- bonus food ----------------
        // one placement since reset so far; placements 2..5 follow
        for (int p = 2; p <= 5; p++) begin
            eat("bonus_eat");
            tick();
            chk("bonus_eat_single", win, 1'b0);
            wait_place("bonus_place");
            chk("bonus_flag", food_bonus, (p == 5) ? 1'b1 : 1'b0);
        end
        head_x = fx;
        head_y = fy;
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        k = 0;
        if (win) k++;
        chk("bonus_win1", win, 1'b1);
        chk("bonus_clr", food_bonus, 1'b0);
        tick();
        if (win) k++;
        chk("bonus_win2", win, 1'b1);
        tick();
        if (win) k++;
        chk("bonus_win3", win, 1'b0);
        chk("bonus_score", k, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
